// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
//   Shared definitions for the instruction-fetch sequencer: default address
//   width, reset fetch address, PC increment and the FSM state encoding.
package fetch_ctrl_pkg;

   localparam int          XLEN_DEF     = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int          PC_INC       = 4;

   // IDLE : no request outstanding
   // WAIT : request outstanding, response will be captured
   // DROP : request outstanding, response will be discarded (redirected)
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if
//   Instruction-memory req/ack port.
//   imem_req   : fetch request, held until imem_ack
//   imem_addr  : fetch address, stable while imem_req is high
//   imem_ack   : response valid, meaningful only while imem_req is high
//   imem_rdata : instruction word, valid with imem_ack
//   master = fetch sequencer side, slave = memory side.
interface fetch_ctrl_if
   import fetch_ctrl_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
);

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [XLEN-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_ctrl_buf.sv
// fetch_buf
//   Single-entry output buffer holding one fetched instruction for IF/ID.
//   clk, rst            : clock, synchronous active-low reset
//   load, load_pc,
//   load_instr          : capture a new entry
//   consume             : entry taken downstream this cycle
//   flush               : discard entry (redirect); wins over load/consume
//   valid, pc, instr    : buffered entry, straight from registers
module fetch_buf
   import fetch_ctrl_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [XLEN-1:0] load_pc,
   input  logic [XLEN-1:0] load_instr,
   input  logic            consume,
   input  logic            flush,
   output logic            valid,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] instr
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values and simulation matches the synthesized flops.
   always_ff @(posedge clk) begin
      if (!rst) begin
         valid <= 1'b0;
         pc    <= '0;
         instr <= '0;
      end else begin
         if (flush)
            valid <= 1'b0;
         else if (load)
            valid <= 1'b1;
         else if (consume)
            valid <= 1'b0;

         if (load && !flush) begin
            pc    <= load_pc;
            instr <= load_instr;
         end
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Instruction-fetch sequencer. Owns the fetch PC, drives the imem req/ack
//   port, applies MEM-stage redirects (also while a fetch is in flight) and
//   buffers one instruction for the IF/ID register, honouring stall.
//   clk, rst        : clock, synchronous active-low reset
//   imem            : instruction-memory port (master side)
//   redirect_valid,
//   redirect_pc     : taken branch / jalr target from MEM
//   stall           : IF/ID cannot accept this cycle
//   fetch_valid,
//   fetch_pc,
//   fetch_instr     : buffered instruction, all registered
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
   input  logic               clk,
   input  logic               rst,
   fetch_ctrl_if.master       imem,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   input  logic               stall,
   output logic               fetch_valid,
   output logic [XLEN-1:0]    fetch_pc,
   output logic [XLEN-1:0]    fetch_instr
);

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] req_addr_q, req_addr_d;
   logic [XLEN-1:0] redirect_tgt;
   logic            buf_valid;
   logic            buf_load;
   logic            launch;
   logic            consume;

   // Instructions are word aligned: low two target bits are dropped.
   assign redirect_tgt = redirect_pc & ~XLEN'(3);

   // Launch only when the buffer is (or is about to become) empty, so a
   // returning ack always finds room in the buffer.
   assign launch  = (state_q == IDLE) && !redirect_valid && (!buf_valid || !stall);
   assign consume = buf_valid && !stall;

   // NOTE: every combinational output gets a default first so no path
   // through the case statement leaves it unassigned (no inferred latch).
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      buf_load   = 1'b0;

      case (state_q)
         IDLE: begin
            if (launch) begin
               state_d    = WAIT;
               req_addr_d = pc_q;
            end
         end
         WAIT: begin
            if (imem.imem_ack) begin
               state_d = IDLE;
               if (!redirect_valid) begin
                  buf_load = 1'b1;
                  pc_d     = pc_q + XLEN'(PC_INC);
               end
            end else if (redirect_valid) begin
               // Request address stays put; the response is thrown away later.
               state_d = DROP;
            end
         end
         DROP: begin
            if (imem.imem_ack)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Redirect wins over sequential advance in every state; last one wins.
      if (redirect_valid)
         pc_d = redirect_tgt;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
      end
   end

   assign imem.imem_req  = (state_q == WAIT) || (state_q == DROP);
   assign imem.imem_addr = req_addr_q;

   fetch_buf #(
      .XLEN (XLEN)
   ) u_buf (
      .clk        (clk),
      .rst        (rst),
      .load       (buf_load),
      .load_pc    (req_addr_q),
      .load_instr (imem.imem_rdata),
      .consume    (consume),
      .flush      (redirect_valid),
      .valid      (buf_valid),
      .pc         (fetch_pc),
      .instr      (fetch_instr)
   );

   assign fetch_valid = buf_valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
//   Self-checking bench for fetch_ctrl: a directed vector table, hand-written
//   multi-cycle redirect/reset sequences, then randomized traffic compared
//   against a transaction-level reference model.
module tb_fetch_ctrl;
   import fetch_ctrl_pkg::*;

   localparam logic [31:0] RST_PC  = 32'h0000_0000;
   localparam int          N_RAND  = 2000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        fetch_valid;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_instr;

   fetch_ctrl_if #(.XLEN(32)) imem_bus ();

   fetch_ctrl #(
      .XLEN     (32),
      .RESET_PC (RST_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem           (imem_bus),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall          (stall),
      .fetch_valid    (fetch_valid),
      .fetch_pc       (fetch_pc),
      .fetch_instr    (fetch_instr)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic rv, input logic [31:0] rpc,
                        input logic st, input logic ack, input logic [31:0] rdata);
      rst                 = r;
      redirect_valid      = rv;
      redirect_pc         = rpc;
      stall               = st;
      imem_bus.imem_ack   = ack;
      imem_bus.imem_rdata = rdata;
   endtask

   // Apply inputs, clock once, return at the following negedge.
   task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc,
                      input logic st, input logic ack, input logic [31:0] rdata);
      drive(r, rv, rpc, st, ack, rdata);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_outs(input string name, input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep, input logic [31:0] ei);
      check({name, ".req"}, {31'b0, imem_bus.imem_req}, {31'b0, er});
      if (er) check({name, ".addr"}, imem_bus.imem_addr, ea);
      check({name, ".valid"}, {31'b0, fetch_valid}, {31'b0, ev});
      if (ev) begin
         check({name, ".pc"}, fetch_pc, ep);
         check({name, ".instr"}, fetch_instr, ei);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct packed {
      logic        rst;
      logic        rv;
      logic [31:0] rpc;
      logic        st;
      logic        ack;
      logic [31:0] rdata;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rpc,
                               input logic st, input logic ack, input logic [31:0] rdata,
                               input logic er, input logic [31:0] ea, input logic ev,
                               input logic [31:0] ep, input logic [31:0] ei);
      vec_t v;
      v = '{r, rv, rpc, st, ack, rdata, er, ea, ev, ep, ei};
      return v;
   endfunction

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   bit          m_busy;     // a memory request is outstanding
   bit          m_poison;   // its response must be thrown away
   logic [31:0] m_addr;
   logic [31:0] m_pc;
   ent_t        m_q[$];     // instructions waiting for IF/ID (at most one)

   task automatic model_step(input logic r, input logic rv, input logic [31:0] rpc,
                             input logic st, input logic ack, input logic [31:0] rdata);
      bit have;
      bit can_launch;
      if (!r) begin
         m_busy   = 0;
         m_poison = 0;
         m_pc     = RST_PC;
         m_q.delete();
      end else begin
         have       = (m_q.size() > 0);
         can_launch = !m_busy && !rv && (!have || !st);
         if (have && !st) void'(m_q.pop_front());
         if (rv) begin
            m_q.delete();
            m_pc = {rpc[31:2], 2'b00};
            if (m_busy && ack) begin
               m_busy   = 0;
               m_poison = 0;
            end else if (m_busy) begin
               m_poison = 1;
            end
         end else if (m_busy) begin
            if (ack) begin
               if (!m_poison) begin
                  m_q.push_back('{pc: m_addr, instr: rdata});
                  m_pc = m_pc + 32'd4;
               end
               m_busy   = 0;
               m_poison = 0;
            end
         end else if (can_launch) begin
            m_busy = 1;
            m_addr = m_pc;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[15];
      logic        r_rst, r_rv, r_st, r_ack;
      logic [31:0] r_rpc, r_rdata;

      // Reset state
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      expect_outs("reset", 0, 0, 0, 0, 0);
      check("reset.fetch_pc", fetch_pc, 32'h0);
      check("reset.fetch_instr", fetch_instr, 32'h0);

      // Zero-wait fetch stream, then full buffer held under stall.
      //              rst rv rpc st ack rdata          req addr         valid pc           instr
      vecs[0]  = mk(1, 0, 0, 0, 0, 32'h0,          1, RST_PC,       0, 0,           0);
      vecs[1]  = mk(1, 0, 0, 0, 1, 32'hA000_0000,  0, 0,            1, 32'h0,       32'hA000_0000);
      vecs[2]  = mk(1, 0, 0, 0, 0, 32'h0,          1, 32'h4,        0, 0,           0);
      vecs[3]  = mk(1, 0, 0, 0, 1, 32'hA000_0001,  0, 0,            1, 32'h4,       32'hA000_0001);
      vecs[4]  = mk(1, 0, 0, 0, 0, 32'h0,          1, 32'h8,        0, 0,           0);
      vecs[5]  = mk(1, 0, 0, 0, 1, 32'hA000_0002,  0, 0,            1, 32'h8,       32'hA000_0002);
      vecs[6]  = mk(1, 0, 0, 1, 0, 32'h0,          0, 0,            1, 32'h8,       32'hA000_0002);
      vecs[7]  = mk(1, 0, 0, 1, 0, 32'h0,          0, 0,            1, 32'h8,       32'hA000_0002);
      vecs[8]  = mk(1, 0, 0, 1, 1, 32'hDEAD_BEEF,  0, 0,            1, 32'h8,       32'hA000_0002);
      vecs[9]  = mk(1, 0, 0, 1, 0, 32'h0,          0, 0,            1, 32'h8,       32'hA000_0002);
      vecs[10] = mk(1, 0, 0, 1, 0, 32'h0,          0, 0,            1, 32'h8,       32'hA000_0002);
      vecs[11] = mk(1, 0, 0, 0, 0, 32'h0,          1, 32'hC,        0, 0,           0);
      vecs[12] = mk(1, 0, 0, 0, 1, 32'hA000_0003,  0, 0,            1, 32'hC,       32'hA000_0003);
      vecs[13] = mk(1, 0, 0, 0, 0, 32'h0,          1, 32'h10,       0, 0,           0);
      vecs[14] = mk(1, 0, 0, 0, 0, 32'h0,          1, 32'h10,       0, 0,           0);

      for (int i = 0; i < 15; i++) begin
         cyc(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].st, vecs[i].ack, vecs[i].rdata);
         expect_outs($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                     vecs[i].exp_valid, vecs[i].exp_pc, vecs[i].exp_instr);
      end

      // Redirect while waiting on a slow memory: address held, data dropped.
      cyc(1, 1, 32'h100, 0, 0, 0);
      expect_outs("slow_redir", 1, 32'h10, 0, 0, 0);
      cyc(1, 0, 0, 0, 1, 32'hBAD0_0010);
      expect_outs("slow_ack", 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      expect_outs("slow_next", 1, 32'h100, 0, 0, 0);
      cyc(1, 0, 0, 0, 1, 32'hB000_0000);
      expect_outs("slow_fill", 0, 0, 1, 32'h100, 32'hB000_0000);

      // Redirect on the same edge as the ack.
      cyc(1, 0, 0, 0, 0, 0);
      expect_outs("same_launch", 1, 32'h104, 0, 0, 0);
      cyc(1, 1, 32'h200, 0, 1, 32'hBAD0_0104);
      expect_outs("same_edge", 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      expect_outs("same_next", 1, 32'h200, 0, 0, 0);

      // Back-to-back redirects while dropping: last one wins, low bits cleared.
      cyc(1, 1, 32'h300, 0, 0, 0);
      expect_outs("drop_r1", 1, 32'h200, 0, 0, 0);
      cyc(1, 1, 32'h403, 0, 0, 0);
      expect_outs("drop_r2", 1, 32'h200, 0, 0, 0);
      cyc(1, 0, 0, 0, 1, 32'hBAD0_0200);
      expect_outs("drop_ack", 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      expect_outs("drop_next", 1, 32'h400, 0, 0, 0);

      // Reset while waiting, then PC wrap.
      cyc(0, 0, 0, 0, 0, 0);
      expect_outs("mid_reset", 0, 0, 0, 0, 0);
      check("mid_reset.fetch_pc", fetch_pc, 32'h0);
      check("mid_reset.fetch_instr", fetch_instr, 32'h0);
      cyc(1, 0, 0, 0, 0, 0);
      expect_outs("post_reset", 1, RST_PC, 0, 0, 0);
      cyc(1, 0, 0, 0, 1, 32'hC000_0000);
      expect_outs("post_fill", 0, 0, 1, RST_PC, 32'hC000_0000);
      cyc(1, 1, 32'hFFFF_FFFC, 0, 0, 0);
      expect_outs("wrap_redir", 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      expect_outs("wrap_launch", 1, 32'hFFFF_FFFC, 0, 0, 0);
      cyc(1, 0, 0, 0, 1, 32'hC000_0001);
      expect_outs("wrap_fill", 0, 0, 1, 32'hFFFF_FFFC, 32'hC000_0001);
      cyc(1, 0, 0, 0, 0, 0);
      expect_outs("wrap_next", 1, 32'h0, 0, 0, 0);

      // Randomized traffic against the reference model.
      drive(0, 0, 0, 0, 0, 0);
      model_step(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < N_RAND; i++) begin
         @(negedge clk);
         check($sformatf("rnd%0d.req", i), {31'b0, imem_bus.imem_req}, {31'b0, m_busy});
         if (m_busy) check($sformatf("rnd%0d.addr", i), imem_bus.imem_addr, m_addr);
         check($sformatf("rnd%0d.valid", i), {31'b0, fetch_valid}, {31'b0, (m_q.size() > 0)});
         if (m_q.size() > 0) begin
            check($sformatf("rnd%0d.pc", i), fetch_pc, m_q[0].pc);
            check($sformatf("rnd%0d.instr", i), fetch_instr, m_q[0].instr);
         end
         r_rst   = ($urandom_range(0, 59) != 0);
         r_rv    = ($urandom_range(0, 7) == 0);
         r_rpc   = $urandom;
         r_st    = ($urandom_range(0, 2) == 0);
         r_ack   = ($urandom_range(0, 1) == 0);
         r_rdata = $urandom;
         drive(r_rst, r_rv, r_rpc, r_st, r_ack, r_rdata);
         model_step(r_rst, r_rv, r_rpc, r_st, r_ack, r_rdata);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer that owns the architectural fetch PC and drives a req/ack instruction-memory port.
- Applies branch/jalr redirects from the MEM stage, including redirects that arrive while a fetch is still in flight.
- Buffers one fetched instruction for the IF/ID register and honours the hazard-unit stall.
- Sits between the redirect logic (branch_valid/jalr) and the IF/ID pipeline register.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- XLEN, 32, address and instruction width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- imem_req  out  1  fetch request; held until imem_ack
- imem_addr  out  XLEN  fetch address; stable while imem_req is high
- imem_ack  in  1  memory response valid; ignored unless imem_req is high
- imem_rdata  in  XLEN  instruction word, valid with imem_ack
- redirect_valid  in  1  taken branch or jalr resolved in MEM
- redirect_pc  in  XLEN  redirect target
- stall  in  1  IF/ID cannot accept this cycle
- fetch_valid  out  1  buffered instruction available
- fetch_pc  out  XLEN  PC of the buffered instruction
- fetch_instr  out  XLEN  buffered instruction word

Behaviour:
- Reset is synchronous and active-low: rst=0 sampled at posedge clk forces:
  - state=IDLE, pc=RESET_PC
  - buf_valid=0, fetch_pc=0, fetch_instr=0
  - imem_req=0 from the next cycle
- An outstanding memory request is abandoned on reset; the memory must tolerate this.
- Outputs:
  - imem_req = (state==WAIT || state==DROP), registered via state.
  - imem_addr = request-address register, loaded from pc at launch.
  - fetch_* come straight from the output buffer registers.
- Consume: fetch_valid && !stall; the buffer empties at that edge unless refilled.
- Launch condition: state==IDLE && !redirect_valid && (!buf_valid || !stall). This guarantees the buffer is empty when the ack returns.
- States:
  - IDLE → WAIT on launch; req_addr<=pc.
  - WAIT, imem_ack && !redirect_valid → IDLE; buf<={req_addr, imem_rdata}, buf_valid<=1, pc<=pc+4.
  - WAIT, !imem_ack && redirect_valid → DROP; pc<=redirect_pc; address stays stable.
  - WAIT, imem_ack && redirect_valid → IDLE; returned data discarded; pc<=redirect_pc.
  - DROP, imem_ack → IDLE; data discarded.
  - DROP, further redirect → pc<=newest redirect_pc (last wins).
  - IDLE, redirect_valid → stay IDLE; pc<=redirect_pc; no launch that cycle.
- Redirect in any state clears buf_valid at that edge. Redirect has priority over consume and over ack capture.
- Throughput: at most one instruction per 2 cycles with a zero-wait memory (the IDLE bubble is intentional). Each ack takes 1 cycle in WAIT.
- Arithmetic: pc+4 wraps modulo 2^XLEN; no carry out.
- redirect_pc[1:0] are forced to 2'b00 on load.
- No combinational path from any input to any output.

Decomposition:
- Shared package:
  - state encoding IDLE=2'd0, WAIT=2'd1, DROP=2'd2
  - XLEN and RESET_PC defaults
  - PC_INC=4
- One natural sub-module: fetch_buf, a single-entry valid/pc/instr register with load, consume and flush controls.
- The FSM and PC register stay in fetch_ctrl.

Test Plan:
1. Reset, then zero-wait memory (ack when req high), stall=0 → imem_addr sequence 0x0, 0x4, 0x8. fetch_valid pulses every 2nd cycle with fetch_pc 0x0, 0x4, 0x8 and the matching rdata.
2. 3-cycle ack latency, redirect_valid=1 with redirect_pc=0x100 in the 2nd WAIT cycle → imem_addr held at the old address until ack. That data is never shown on fetch_valid. The next request has imem_addr=0x100.
3. Redirect 0x200 on the same edge as imem_ack → data discarded, buf_valid=0, next imem_addr=0x200.
4. Buffer full (pc 0x8), stall=1 for 5 cycles → imem_req stays 0 and fetch_* are held. Dropping stall → consume, launch at 0xC in the same cycle.
5. In DROP, redirects 0x300 then 0x400 before ack → after ack, next imem_addr=0x400.
6. rst=0 for one cycle while in WAIT → next cycle imem_req=0, fetch_valid=0. After reset, the first imem_addr is RESET_PC. Redirect 0xFFFF_FFFC followed by an ack → next address 0x0 (wrap).
